multicycle_control_fsm: RTL and testbench

//  Control unit that consumes the 4-bit opcode (instruction[15:12]) emitted by the 16-bit datapath.
//  It drives every datapath control strobe: RegDst, Branch, MemRead, MemWrite, RegWrite,

---
 rtl/multicycle_control_fsm_pkg.sv | 35 +++
 rtl/multicycle_control_fsm_decode.sv | 23 ++
 rtl/multicycle_control_fsm.sv | 129 ++++++++++++
 tb/tb_multicycle_control_fsm.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/multicycle_control_fsm_pkg.sv
// Shared encodings for the multi-cycle control unit: opcodes, states, ALUOp
// values and the decoded opcode class.
package multicycle_control_fsm_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5
  } state_t;

  localparam logic [3:0] OP_R     = 4'b0000;
  localparam logic [3:0] OP_SHIFT = 4'b0001;
  localparam logic [3:0] OP_ADDI  = 4'b0010;
  localparam logic [3:0] OP_LW    = 4'b0100;
  localparam logic [3:0] OP_SW    = 4'b0101;
  localparam logic [3:0] OP_BEQ   = 4'b0110;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  typedef struct packed {
    logic is_r;
    logic is_shift;
    logic is_addi;
    logic is_lw;
    logic is_sw;
    logic is_beq;
    logic illegal;
  } op_class_t;

endpackage

// File: rtl/multicycle_control_fsm_decode.sv
// Combinational opcode classifier: one-hot class flags, illegal for anything
// outside the defined instruction set.
module opcode_class_decode
  import multicycle_control_fsm_pkg::*;
(
  input  logic [3:0] opcode_i,
  output op_class_t  cls_o
);

  always_comb begin
    cls_o = '0;
    case (opcode_i)
      OP_R:     cls_o.is_r     = 1'b1;
      OP_SHIFT: cls_o.is_shift = 1'b1;
      OP_ADDI:  cls_o.is_addi  = 1'b1;
      OP_LW:    cls_o.is_lw    = 1'b1;
      OP_SW:    cls_o.is_sw    = 1'b1;
      OP_BEQ:   cls_o.is_beq   = 1'b1;
      default:  cls_o.illegal  = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle control unit: sequences FETCH/DECODE/EXEC/MEM/WB per opcode,
// stalls in MEM on mem_ready and aborts after MEM_TIMEOUT cycles.
module multicycle_control_fsm
  import multicycle_control_fsm_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [3:0] opcode_i,
  input  logic       mem_ready_i,
  output logic       reg_dst_o,
  output logic       branch_o,
  output logic       mem_read_o,
  output logic       mem_write_o,
  output logic       reg_write_o,
  output logic       mem_to_reg_o,
  output logic       alu_src_o,
  output logic       shift_o,
  output logic [1:0] alu_op_o,
  output logic       pc_write_o,
  output logic       ir_write_o,
  output logic       illegal_op_o,
  output logic       mem_error_o,
  output logic [2:0] state_dbg_o
);

  localparam int CW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

  state_t          state_q;
  logic [3:0]      opcode_q;
  logic [CW-1:0]   cnt_q;
  op_class_t       cls;
  logic [3:0]      dec_op;
  logic            timeout;

  // The IR is itself a register, so in DECODE its opcode is classified
  // directly; afterwards the latched copy drives every decision.
  assign dec_op  = (state_q == S_DECODE) ? opcode_i : opcode_q;
  assign timeout = (cnt_q == CW'(MEM_TIMEOUT - 1));

  opcode_class_decode u_dec (
    .opcode_i (dec_op),
    .cls_o    (cls)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      opcode_q <= '0;
      cnt_q    <= '0;
    end else begin
      case (state_q)
        S_IDLE:   state_q <= S_FETCH;
        S_FETCH:  state_q <= S_DECODE;
        S_DECODE: begin
          opcode_q <= opcode_i;
          state_q  <= cls.illegal ? S_FETCH : S_EXEC;
        end
        S_EXEC: begin
          cnt_q <= '0;
          if (cls.is_lw || cls.is_sw) state_q <= S_MEM;
          else if (cls.is_beq)        state_q <= S_FETCH;
          else                        state_q <= S_WB;
        end
        S_MEM: begin
          if (mem_ready_i)  state_q <= cls.is_lw ? S_WB : S_FETCH;
          else if (timeout) state_q <= S_FETCH;
          else              cnt_q   <= cnt_q + 1'b1;
        end
        S_WB:     state_q <= S_FETCH;
        default:  state_q <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    reg_dst_o    = 1'b0;
    branch_o     = 1'b0;
    mem_read_o   = 1'b0;
    mem_write_o  = 1'b0;
    reg_write_o  = 1'b0;
    mem_to_reg_o = 1'b0;
    alu_src_o    = 1'b0;
    shift_o      = 1'b0;
    alu_op_o     = ALUOP_ADD;
    pc_write_o   = 1'b0;
    ir_write_o   = 1'b0;
    illegal_op_o = 1'b0;
    mem_error_o  = 1'b0;
    case (state_q)
      S_FETCH:  ir_write_o = 1'b1;
      S_DECODE: begin
        illegal_op_o = cls.illegal;
        pc_write_o   = cls.illegal;
      end
      S_EXEC, S_WB: begin
        alu_src_o = cls.is_addi | cls.is_lw | cls.is_sw;
        shift_o   = cls.is_shift;
        alu_op_o  = cls.is_r ? ALUOP_FUNCT : (cls.is_beq ? ALUOP_SUB : ALUOP_ADD);
        if (state_q == S_EXEC) begin
          branch_o   = cls.is_beq;
          pc_write_o = cls.is_beq;
        end else begin
          reg_write_o  = 1'b1;
          pc_write_o   = 1'b1;
          reg_dst_o    = cls.is_r | cls.is_shift;
          mem_to_reg_o = cls.is_lw;
        end
      end
      S_MEM: begin
        alu_src_o   = 1'b1;
        mem_read_o  = cls.is_lw;
        mem_write_o = cls.is_sw;
        // A ready on the timeout cycle completes normally, no error.
        if (mem_ready_i) begin
          pc_write_o = cls.is_sw;
        end else if (timeout) begin
          mem_error_o = 1'b1;
          pc_write_o  = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign state_dbg_o = state_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Self-checking bench: per-cycle traces from an instruction-level model,
// table vectors with hand-derived latencies, reset and random sequences.
module tb_multicycle_control_fsm;

  localparam int T = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] opcode;
  logic       mem_ready;
  logic       reg_dst, branch, mem_read, mem_write, reg_write, mem_to_reg;
  logic       alu_src, shift, pc_write, ir_write, illegal_op, mem_error;
  logic [1:0] alu_op;
  logic [2:0] state_dbg;

  multicycle_control_fsm #(.MEM_TIMEOUT(T)) dut (
    .clk_i(clk), .rst_i(rst), .opcode_i(opcode), .mem_ready_i(mem_ready),
    .reg_dst_o(reg_dst), .branch_o(branch), .mem_read_o(mem_read),
    .mem_write_o(mem_write), .reg_write_o(reg_write), .mem_to_reg_o(mem_to_reg),
    .alu_src_o(alu_src), .shift_o(shift), .alu_op_o(alu_op),
    .pc_write_o(pc_write), .ir_write_o(ir_write), .illegal_op_o(illegal_op),
    .mem_error_o(mem_error), .state_dbg_o(state_dbg)
  );

  always #5 clk = ~clk;

  typedef logic [16:0] ov_t;
  ov_t dut_v;
  assign dut_v = {state_dbg, reg_dst, branch, mem_read, mem_write, reg_write,
                  mem_to_reg, alu_src, shift, alu_op, pc_write, ir_write,
                  illegal_op, mem_error};

  int checks = 0;
  int errors = 0;

  function automatic ov_t mk(input int st, input bit rd, br, mr, mw, rw, m2r, as, sh,
                             input logic [1:0] aop, input bit pcw, irw, ill, me);
    logic [2:0] s3;
    s3 = 3'(st);
    return {s3, rd, br, mr, mw, rw, m2r, as, sh, aop, pcw, irw, ill, me};
  endfunction

  task automatic chk(input string name, input int cyc, input logic [31:0] act, exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d got=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  // Instruction-level model: expected outputs per cycle starting at FETCH,
  // plus the mem_ready value to drive on each cycle.
  ov_t trace[$];
  bit  rdy[$];

  task automatic build(input logic [3:0] op, input int w);
    bit r, sh, ad, lw, sw, bq, ill, as;
    logic [1:0] aop;
    int n;
    r = (op == 4'd0); sh = (op == 4'd1); ad = (op == 4'd2);
    lw = (op == 4'd4); sw = (op == 4'd5); bq = (op == 4'd6);
    ill = !(r | sh | ad | lw | sw | bq);
    as  = ad | lw | sw;
    aop = r ? 2'b10 : (bq ? 2'b01 : 2'b00);
    trace.delete(); rdy.delete();
    trace.push_back(mk(1, 0,0,0,0,0,0,0,0, 2'b00, 0,1,0,0)); rdy.push_back(1'($urandom));
    if (ill) begin
      trace.push_back(mk(2, 0,0,0,0,0,0,0,0, 2'b00, 1,0,1,0)); rdy.push_back(1'($urandom));
      return;
    end
    trace.push_back(mk(2, 0,0,0,0,0,0,0,0, 2'b00, 0,0,0,0)); rdy.push_back(1'($urandom));
    trace.push_back(mk(3, 0,bq,0,0,0,0,as,sh, aop, bq,0,0,0)); rdy.push_back(1'($urandom));
    if (bq) return;
    if (lw | sw) begin
      n = (w < T) ? w + 1 : T;
      for (int k = 0; k < n; k++) begin
        bit last, ready, err;
        last  = (k == n - 1);
        ready = last && (w < T);
        err   = last && (w >= T);
        trace.push_back(mk(4, 0,0,lw,sw,0,0,1,0, 2'b00, (sw && ready) || err, 0,0,err));
        rdy.push_back(ready);
      end
      if (sw || w >= T) return;
    end
    trace.push_back(mk(5, r|sh,0,0,0,1,lw,as,sh, aop, 1,0,0,0)); rdy.push_back(1'($urandom));
  endtask

  // Runs one instruction from FETCH until the DUT is back in FETCH.
  task automatic run(input string name, input logic [3:0] op, input int w,
                     input int exp_len, input int exp_rw, input int exp_err);
    int c, pcw_n, rw_n, err_n;
    bit done;
    build(op, w);
    c = 0; pcw_n = 0; rw_n = 0; err_n = 0; done = 0;
    while (!done) begin
      @(negedge clk);
      // Opcode is only meaningful in DECODE; scramble it elsewhere.
      opcode    = (c == 1) ? op : 4'($urandom);
      mem_ready = (c < trace.size()) ? rdy[c] : 1'b0;
      #1;
      if (c < trace.size()) chk({name, "_trace"}, c, 32'(dut_v), 32'(trace[c]));
      else                  chk({name, "_overrun"}, c, 32'(c), 32'(trace.size()));
      pcw_n += int'(pc_write);
      rw_n  += int'(reg_write);
      err_n += int'(mem_error);
      @(posedge clk); #1;
      c++;
      if (state_dbg == 3'd1) done = 1;
      else if (c > 64) begin
        chk({name, "_timeout"}, c, 32'(state_dbg), 32'd1);
        done = 1;
      end
    end
    chk({name, "_len"}, c, 32'(c), 32'(exp_len));
    chk({name, "_pcw"}, c, 32'(pcw_n), 32'd1);
    chk({name, "_rw"}, c, 32'(rw_n), 32'(exp_rw));
    chk({name, "_err"}, c, 32'(err_n), 32'(exp_err));
  endtask

  typedef struct {
    string      name;
    logic [3:0] op;
    int         w;
    int         len;
    int         rw;
    int         err;
  } vec_t;

  vec_t tbl[12];

  initial begin
    tbl[0]  = '{"rtype",     4'b0000, 0,  4,  1, 0};
    tbl[1]  = '{"shift",     4'b0001, 0,  4,  1, 0};
    tbl[2]  = '{"addi",      4'b0010, 0,  4,  1, 0};
    tbl[3]  = '{"lw_fast",   4'b0100, 0,  5,  1, 0};
    tbl[4]  = '{"lw_wait3",  4'b0100, 3,  8,  1, 0};
    tbl[5]  = '{"sw_fast",   4'b0101, 0,  4,  0, 0};
    tbl[6]  = '{"sw_tmo",    4'b0101, 99, 19, 0, 1};
    tbl[7]  = '{"sw_edge",   4'b0101, 15, 19, 0, 0};
    tbl[8]  = '{"lw_edge",   4'b0100, 15, 20, 1, 0};
    tbl[9]  = '{"beq",       4'b0110, 0,  3,  0, 0};
    tbl[10] = '{"ill_1111",  4'b1111, 0,  2,  0, 0};
    tbl[11] = '{"ill_0011",  4'b0011, 0,  2,  0, 0};

    rst = 1'b1; opcode = 4'd0; mem_ready = 1'b0;
    #2 chk("reset_outputs", 0, 32'(dut_v), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    #1 chk("idle_outputs", 0, 32'(dut_v), 32'd0);

    foreach (tbl[i]) run(tbl[i].name, tbl[i].op, tbl[i].w, tbl[i].len, tbl[i].rw, tbl[i].err);

    // Reset asserted mid-EXEC of an R-type clears everything immediately.
    @(negedge clk); opcode = 4'($urandom);
    @(negedge clk); opcode = 4'b0000;
    @(negedge clk); opcode = 4'($urandom); #1;
    chk("mid_exec_aluop", 0, 32'({state_dbg, alu_op}), 32'({3'd3, 2'b10}));
    rst = 1'b1; #1;
    chk("mid_exec_reset", 0, 32'(dut_v), 32'd0);
    @(posedge clk); #1 chk("reset_hold", 0, 32'(dut_v), 32'd0);
    @(negedge clk) rst = 1'b0;
    #1 chk("post_reset_idle", 0, 32'(dut_v), 32'd0);
    run("after_reset", 4'b0000, 0, 4, 1, 0);

    for (int i = 0; i < 150; i++) begin
      logic [3:0] op;
      int w, len, rw, err, wt;
      bit lw, sw, bq, alu;
      op  = (i % 3 == 0) ? 4'($urandom) : 4'($urandom_range(0, 6));
      w   = $urandom_range(0, 20);
      lw  = (op == 4'd4); sw = (op == 4'd5); bq = (op == 4'd6);
      alu = (op <= 4'd2);
      wt  = (w < T - 1) ? w : T - 1;
      err = ((lw || sw) && w >= T) ? 1 : 0;
      len = bq ? 3 : alu ? 4 : sw ? 4 + wt : lw ? ((err != 0) ? 4 + wt : 5 + wt) : 2;
      rw  = (alu || (lw && err == 0)) ? 1 : 0;
      run("random", op, w, len, rw, err);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

endmodule
